// File: rtl/mithril_add_arbiter.sv
// mithril_add_arbiter
// Round-robin sequencer that shares one mithril_add_secure adder among NREQ
// requesters. The winner's operands are captured on grant, one add is run,
// the result is returned to its owner, and every operand/result buffer is
// zeroized before the next grant.
// Optional build macro: MITHRIL_ARB_TIMEOUT_EN adds a per-wait-state watchdog
// that forces an error response after TIMEOUT_CYCLES cycles of waiting.
module mithril_add_arbiter #(
  parameter int WIDTH          = 256,
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  add_start,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_result,
  input  logic                  add_carry,
  input  logic                  add_done,
  input  logic                  add_error
);

  localparam int IDXW = $clog2(NREQ);

  // Elaboration guard: the watchdog counter is 8 bits, and the requester
  // index logic is sized for 2..8 requesters.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || NREQ < 2 || NREQ > 8) begin : g_param_check
    $error("mithril_add_arbiter: parameter out of range");
  end

  // Three-bit encoding leaves spare codes; any of them falls back to idle.
  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISSUE   = 3'd1,
    ARB_RELEASE = 3'd2,
    ARB_RESPOND = 3'd3
  } arb_state_t;

  arb_state_t       state_reg, state_next;
  logic [IDXW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDXW-1:0]  owner_reg, owner_next;
  logic [WIDTH-1:0] a_buf_reg, a_buf_next;
  logic [WIDTH-1:0] b_buf_reg, b_buf_next;
  logic [WIDTH-1:0] r_buf_reg, r_buf_next;
  logic             r_carry_reg, r_carry_next;
  logic             r_error_reg, r_error_next;
`ifdef MITHRIL_ARB_TIMEOUT_EN
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
`endif

  // Per-requester operand slices, unpacked so the winner can be indexed.
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  logic            sel_found;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW-1:0] sel_ptr_next;
  int              scan_idx;

  // Round-robin pick: scan from lowest to highest priority so the request
  // closest to rr_ptr_reg is the last one written and therefore wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      scan_idx = int'(rr_ptr_reg) + j;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (req[IDXW'(scan_idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(scan_idx);
      end
    end
    sel_ptr_next = (sel_idx == IDXW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Next-state, buffer updates and all outputs; outputs default to zero so
  // no operand or result data leaks outside the state that owns it.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    owner_next    = owner_reg;
    a_buf_next    = a_buf_reg;
    b_buf_next    = b_buf_reg;
    r_buf_next    = r_buf_reg;
    r_carry_next  = r_carry_reg;
    r_error_next  = r_error_reg;
`ifdef MITHRIL_ARB_TIMEOUT_EN
    wait_cnt_next = '0;
`endif
    gnt        = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_carry  = 1'b0;
    rsp_error  = 1'b0;
    busy       = 1'b1;
    add_start  = 1'b0;
    add_a      = '0;
    add_b      = '0;

    case (state_reg)
      ARB_IDLE: begin
        busy = 1'b0;
        // rst_n gating keeps gnt quiet while reset is held with req high.
        if (sel_found && rst_n) begin
          gnt[sel_idx] = 1'b1;
          a_buf_next   = op_a[sel_idx];
          b_buf_next   = op_b[sel_idx];
          owner_next   = sel_idx;
          rr_ptr_next  = sel_ptr_next;
          state_next   = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        add_start = 1'b1;
        add_a     = a_buf_reg;
        add_b     = b_buf_reg;
        if (add_done) begin
          r_buf_next   = add_result;
          r_carry_next = add_carry;
          r_error_next = add_error;
          state_next   = ARB_RELEASE;
        end
`ifdef MITHRIL_ARB_TIMEOUT_EN
        else if (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
          r_buf_next   = '0;
          r_carry_next = 1'b0;
          r_error_next = 1'b1;
          state_next   = ARB_RELEASE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
`endif
      end

      ARB_RELEASE: begin
        // Start is dropped; wait for the adder to acknowledge by lowering done.
        if (!add_done) begin
          state_next = ARB_RESPOND;
        end
`ifdef MITHRIL_ARB_TIMEOUT_EN
        else if (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
          r_error_next = 1'b1;
          state_next   = ARB_RESPOND;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
`endif
      end

      ARB_RESPOND: begin
        rsp_valid[owner_reg] = 1'b1;
        rsp_result   = r_buf_reg;
        rsp_carry    = r_carry_reg;
        rsp_error    = r_error_reg;
        a_buf_next   = '0;
        b_buf_next   = '0;
        r_buf_next   = '0;
        r_carry_next = 1'b0;
        r_error_next = 1'b0;
        state_next   = ARB_IDLE;
      end

      default: begin
        busy         = 1'b0;
        a_buf_next   = '0;
        b_buf_next   = '0;
        r_buf_next   = '0;
        r_carry_next = 1'b0;
        r_error_next = 1'b0;
        state_next   = ARB_IDLE;
      end
    endcase
  end

  // State and buffer registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ARB_IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      a_buf_reg    <= '0;
      b_buf_reg    <= '0;
      r_buf_reg    <= '0;
      r_carry_reg  <= 1'b0;
      r_error_reg  <= 1'b0;
`ifdef MITHRIL_ARB_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      owner_reg    <= owner_next;
      a_buf_reg    <= a_buf_next;
      b_buf_reg    <= b_buf_next;
      r_buf_reg    <= r_buf_next;
      r_carry_reg  <= r_carry_next;
      r_error_reg  <= r_error_next;
`ifdef MITHRIL_ARB_TIMEOUT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mithril_add_arbiter.sv
// tb_mithril_add_arbiter
// Directed bench for mithril_add_arbiter with a simple adder model attached.
// A transaction-level reference (round-robin pick, fixed start/done timing,
// plain 257-bit addition) is compared against the DUT on every cycle, and
// hand-computed literals pin grant order, sums, carries and latencies.
// Define MITHRIL_ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_mithril_add_arbiter;
  localparam int WIDTH          = 256;
  localparam int NREQ           = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;
  logic                  rsp_error;
  logic                  busy;
  logic                  add_start;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_result;
  logic                  add_carry;
  logic                  add_done;
  logic                  add_error;

  mithril_add_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_error(rsp_error), .busy(busy),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_carry(add_carry), .add_done(add_done),
    .add_error(add_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder model: done rises add_lat cycles after start first goes high and
  // falls as soon as start drops; add_hang keeps done low forever.
  int   add_lat = 2;
  bit   add_hang = 1'b0;
  bit   add_err_inj = 1'b0;
  int   add_cnt;
  logic add_done_reg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_cnt      <= 0;
      add_done_reg <= 1'b0;
    end else if (!add_start) begin
      add_cnt      <= 0;
      add_done_reg <= 1'b0;
    end else if (!add_hang) begin
      if (add_cnt >= add_lat - 1) add_done_reg <= 1'b1;
      else add_cnt <= add_cnt + 1;
    end
  end

  assign add_done = add_done_reg & add_start;
  assign {add_carry, add_result} = add_done ? ({1'b0, add_a} + {1'b0, add_b}) : '0;
  assign add_error = add_done & add_err_inj;

  // Observed events, recorded for the literal checks.
  int               g_idx_q[$];
  int               g_cyc_q[$];
  int               r_idx_q[$];
  int               r_cyc_q[$];
  logic [WIDTH-1:0] r_res_q[$];
  bit               r_car_q[$];
  bit               r_err_q[$];

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model plus per-cycle compare, sampled on the falling edge.
  bit               m_busy = 1'b0;
  int               m_ptr = 0;
  int               m_owner = 0;
  int               m_k = 0;
  int               m_slen = 0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  logic [WIDTH:0]   m_sum = '0;
  bit               m_err = 1'b0;

  initial begin
    logic [NREQ-1:0]  e_gnt, e_rsp;
    logic [WIDTH-1:0] e_res, e_a, e_b;
    logic             e_carry, e_err, e_start;
    int               pick, idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_ctrl", {gnt, rsp_valid, busy, add_start, rsp_carry, rsp_error}, '0);
        chk("reset_add_a", add_a, '0);
        chk("reset_rsp_result", rsp_result, '0);
        m_busy = 1'b0;
        m_ptr  = 0;
        m_k    = 0;
      end else begin
        pick = -1;
        if (!m_busy) begin
          for (int j = NREQ - 1; j >= 0; j--) begin
            idx = (m_ptr + j) % NREQ;
            if (req[idx]) pick = idx;
          end
        end
        e_gnt = '0;
        if (pick >= 0) e_gnt[pick] = 1'b1;
        e_rsp = '0; e_res = '0; e_carry = 1'b0; e_err = 1'b0;
        e_a = '0; e_b = '0; e_start = 1'b0;
        if (m_busy) begin
          m_k++;
          e_start = (m_k <= m_slen);
          if (e_start) begin
            e_a = m_a;
            e_b = m_b;
          end
          if (m_k == m_slen + 2) begin
            e_rsp[m_owner] = 1'b1;
            e_res   = m_sum[WIDTH-1:0];
            e_carry = m_sum[WIDTH];
            e_err   = m_err;
          end
        end
        chk("gnt", gnt, e_gnt);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_carry", rsp_carry, e_carry);
        chk("rsp_error", rsp_error, e_err);
        chk("busy", busy, m_busy);
        chk("add_start", add_start, e_start);
        chk("add_a", add_a, e_a);
        chk("add_b", add_b, e_b);

        if (gnt != '0) begin
          g_idx_q.push_back(onehot_idx(gnt));
          g_cyc_q.push_back(cyc);
        end
        if (rsp_valid != '0) begin
          r_idx_q.push_back(onehot_idx(rsp_valid));
          r_cyc_q.push_back(cyc);
          r_res_q.push_back(rsp_result);
          r_car_q.push_back(rsp_carry);
          r_err_q.push_back(rsp_error);
        end

        if (e_rsp != '0) m_busy = 1'b0;
        if (pick >= 0) begin
          m_busy  = 1'b1;
          m_k     = 0;
          m_owner = pick;
          m_ptr   = (pick + 1) % NREQ;
          m_a     = req_a[pick*WIDTH +: WIDTH];
          m_b     = req_b[pick*WIDTH +: WIDTH];
          if (add_hang) begin
            m_slen = TIMEOUT_CYCLES;
            m_sum  = '0;
            m_err  = 1'b1;
          end else begin
            m_slen = add_lat + 1;
            m_sum  = {1'b0, m_a} + {1'b0, m_b};
            m_err  = add_err_inj;
          end
        end
      end
    end
  end

  task automatic clear_log();
    g_idx_q.delete(); g_cyc_q.delete(); r_idx_q.delete(); r_cyc_q.delete();
    r_res_q.delete(); r_car_q.delete(); r_err_q.delete();
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req[i] = 1'b1;
  endtask

  // Wait for gnt[i], then drop req[i] just after the capturing edge.
  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < 100);
    if (!gnt[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL gnt_wait: no gnt[%0d] within %0d cycles", i, n);
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[i] && n < 300);
    if (!rsp_valid[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL rsp_wait: no rsp_valid[%0d] within %0d cycles", i, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_log();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int exp_sums[5]  = '{11, 22, 33, 44, 11};

  initial begin
    int n, guard;
    rst_n = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_busy", busy, 1'b0);
    chk("por_gnt", gnt, '0);
    chk("por_add_start", add_start, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Reset while the adder is being driven: everything must drop at once.
    @(posedge clk); #1;
    set_req(2, 256'd5, 256'd7);
    wait_gnt(2);
    chk("t1_in_issue", add_start, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_busy_now", busy, 1'b0);
    chk("t1_add_start_now", add_start, 1'b0);
    chk("t1_add_a_now", add_a, '0);
    @(posedge clk); #1;
    chk("t1_ctrl_after_edge", {busy, add_start, gnt, rsp_valid}, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_log();
    repeat (3) @(posedge clk);
    chk("t1_no_rsp", r_idx_q.size(), 0);

    // Single request on index 2: 5 + 7.
    #1;
    add_lat = 2;
    set_req(2, 256'd5, 256'd7);
    wait_gnt(2);
    wait_rsp(2);
    chk("t2_gnt_idx", g_idx_q[0], 2);
    chk("t2_rsp_idx", r_idx_q[0], 2);
    chk("t2_result", r_res_q[0], 12);
    chk("t2_carry", r_car_q[0], 1'b0);
    chk("t2_latency", r_cyc_q[0] - g_cyc_q[0], 5);
    chk("t2_one_gnt", g_idx_q.size(), 1);

    // All-ones plus one on index 0: wraps to zero with carry out.
    @(posedge clk); #1;
    clear_log();
    add_lat = 4;
    set_req(0, {WIDTH{1'b1}}, 256'd1);
    wait_gnt(0);
    wait_rsp(0);
    chk("t3_result", r_res_q[0], 0);
    chk("t3_carry", r_car_q[0], 1'b1);
    chk("t3_latency", r_cyc_q[0] - g_cyc_q[0], 7);
    @(negedge clk);
    chk("t3_add_a_zero", add_a, '0);
    chk("t3_rsp_result_zero", rsp_result, '0);

    // Index 3 granted; index 1 raised during its add must wait for the response.
    @(posedge clk); #1;
    clear_log();
    add_lat = 3;
    set_req(3, 256'd100, 256'd23);
    wait_gnt(3);
    set_req(1, 256'd40, 256'd2);
    wait_rsp(3);
    wait_gnt(1);
    wait_rsp(1);
    chk("t5_first_gnt", g_idx_q[0], 3);
    chk("t5_second_gnt", g_idx_q[1], 1);
    chk("t5_gnt1_after_rsp3", g_cyc_q[1] - r_cyc_q[0], 1);
    chk("t5_result3", r_res_q[0], 123);
    chk("t5_result1", r_res_q[1], 42);

    // All four requesting continuously from a fresh pointer.
    do_reset();
    @(posedge clk); #1;
    add_lat = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i + 1), WIDTH'(10 * (i + 1)));
    n = 0;
    guard = 0;
    while (n < 5 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (gnt != '0) n++;
    end
    @(posedge clk); #1;
    req = '0;
    chk("t4_grant_count", n, 5);
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_gnt_order", g_idx_q[i], exp_order[i]);
      chk("t4_rsp_order", r_idx_q[i], exp_order[i]);
      chk("t4_rsp_sum", r_res_q[i], exp_sums[i]);
    end
    chk("t4_latency", r_cyc_q[0] - g_cyc_q[0], 4);

    // Adder error is forwarded on the response.
    @(posedge clk); #1;
    clear_log();
    add_lat = 2;
    add_err_inj = 1'b1;
    set_req(1, 256'd3, 256'd4);
    wait_gnt(1);
    wait_rsp(1);
    add_err_inj = 1'b0;
    chk("t7_error", r_err_q[0], 1'b1);
    chk("t7_result", r_res_q[0], 7);

`ifdef MITHRIL_ARB_TIMEOUT_EN
    // Adder never completes: watchdog returns an error with a zero result.
    @(posedge clk); #1;
    clear_log();
    add_hang = 1'b1;
    set_req(2, 256'd9, 256'd9);
    wait_gnt(2);
    wait_rsp(2);
    add_hang = 1'b0;
    chk("t6_error", r_err_q[0], 1'b1);
    chk("t6_result", r_res_q[0], 0);
    chk("t6_latency", r_cyc_q[0] - g_cyc_q[0], TIMEOUT_CYCLES + 2);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish, %0d failed so far", tests_failed);
    $fatal(1, "global timeout");
  end

endmodule
